tau_mac_sched: RTL and testbench

- Shares one tau_mac instance between NUM_REQ requesters, each submitting dot-product jobs as a stream of (a, b) operand pairs.
- Per job: grants one requester round-robin, clears the MAC accumulator, issues one start per pair and waits for mac_valid.
- Returns the final accumulated sum tagged with the requester ID.
- Sits between the operand producers and the tau_mac datapath; it is the only driver of the MAC's start/operand/clear inputs.

---
 rtl/tau_mac_sched.sv | 213 +++++++++++++++++++++
 tb/tb_tau_mac_sched.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tau_mac_sched.sv
// tau_mac_sched: round-robin scheduler sharing one tau_mac between NUM_REQ
// requesters. Each job is a stream of (a, b) pairs. The job clears the MAC,
// issues one start per pair, and returns the final sum tagged with the owner ID.
// Optional watchdog on the MAC wait: define TAU_MAC_SCHED_TIMEOUT_EN.
module tau_mac_sched #(
    parameter int NUM_REQ        = 2,
    parameter int BITWIDTH       = 8,
    parameter int OUT_WIDTH      = 16,
    parameter int MAX_LEN        = 16,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0]  req_b,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic                         mac_clr,
    output logic                         mac_start,
    output logic [BITWIDTH-1:0]          mac_a,
    output logic [BITWIDTH-1:0]          mac_b,
    input  logic                         mac_valid,
    input  logic [OUT_WIDTH-1:0]         mac_sum,
    output logic                         resp_valid,
    input  logic                         resp_ready,
    output logic [ID_W-1:0]              resp_id,
    output logic [OUT_WIDTH-1:0]         resp_sum,
    output logic                         resp_trunc,
    output logic                         resp_err,
    output logic                         busy
);

    localparam int CNT_W = $clog2(MAX_LEN + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 state_q;
    logic [ID_W-1:0]        rr_ptr_q;
    logic [ID_W-1:0]        owner_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   last_q;
    logic [NUM_REQ-1:0]     req_ready_q;
    logic                   mac_clr_q;
    logic                   mac_start_q;
    logic [BITWIDTH-1:0]    mac_a_q;
    logic [BITWIDTH-1:0]    mac_b_q;
    logic                   resp_valid_q;
    logic [ID_W-1:0]        resp_id_q;
    logic [OUT_WIDTH-1:0]   resp_sum_q;
    logic                   resp_trunc_q;
    logic                   busy_q;

    logic                   grant_found_d;
    logic [ID_W-1:0]        grant_id_d;
    logic [NUM_REQ-1:0]     owner_onehot;

    logic [BITWIDTH-1:0]    opa [NUM_REQ];
    logic [BITWIDTH-1:0]    opb [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign opa[g] = req_a[g*BITWIDTH +: BITWIDTH];
        assign opb[g] = req_b[g*BITWIDTH +: BITWIDTH];
    end

    assign owner_onehot = NUM_REQ'(1) << owner_q;

`ifdef TAU_MAC_SCHED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_q;
    logic             resp_err_q;
    assign resp_err = resp_err_q;
`else
    assign resp_err = 1'b0;
`endif

    // Round-robin search: first valid requester at or after the pointer, wrapping.
    always_comb begin
        int unsigned idx;
        idx           = 0;
        grant_found_d = 1'b0;
        grant_id_d    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr_q) + i) % NUM_REQ;
            if (!grant_found_d && req_valid[ID_W'(idx)]) begin
                grant_found_d = 1'b1;
                grant_id_d    = ID_W'(idx);
            end
        end
    end

    // Job FSM; every output is a register updated on the transition into its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            cnt_q        <= '0;
            last_q       <= 1'b0;
            req_ready_q  <= '0;
            mac_clr_q    <= 1'b0;
            mac_start_q  <= 1'b0;
            mac_a_q      <= '0;
            mac_b_q      <= '0;
            resp_valid_q <= 1'b0;
            resp_id_q    <= '0;
            resp_sum_q   <= '0;
            resp_trunc_q <= 1'b0;
            busy_q       <= 1'b0;
`ifdef TAU_MAC_SCHED_TIMEOUT_EN
            tmo_q        <= '0;
            resp_err_q   <= 1'b0;
`endif
        end else begin
            // Pulses default low so each is high for exactly one state visit.
            mac_clr_q   <= 1'b0;
            mac_start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (grant_found_d) begin
                        owner_q   <= grant_id_d;
                        mac_clr_q <= 1'b1;
                        busy_q    <= 1'b1;
                        state_q   <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    cnt_q       <= '0;
                    req_ready_q <= owner_onehot;
                    state_q     <= S_FETCH;
                end
                S_FETCH: begin
                    if (req_valid[owner_q]) begin
                        mac_a_q     <= opa[owner_q];
                        mac_b_q     <= opb[owner_q];
                        last_q      <= req_last[owner_q];
                        cnt_q       <= cnt_q + 1'b1;
                        req_ready_q <= '0;
                        mac_start_q <= 1'b1;
                        state_q     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
`ifdef TAU_MAC_SCHED_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    if (mac_valid) begin
                        if (last_q || (cnt_q == CNT_W'(MAX_LEN))) begin
                            resp_sum_q   <= mac_sum;
                            resp_id_q    <= owner_q;
                            resp_trunc_q <= !last_q;
                            resp_valid_q <= 1'b1;
`ifdef TAU_MAC_SCHED_TIMEOUT_EN
                            resp_err_q   <= 1'b0;
`endif
                            state_q      <= S_RESP;
                        end else begin
                            req_ready_q <= owner_onehot;
                            state_q     <= S_FETCH;
                        end
                    end
`ifdef TAU_MAC_SCHED_TIMEOUT_EN
                    else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
                        resp_sum_q   <= '0;
                        resp_id_q    <= owner_q;
                        resp_trunc_q <= 1'b0;
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= S_RESP;
                    end else begin
                        tmo_q <= tmo_q + 1'b1;
                    end
`endif
                end
                S_RESP: begin
                    if (resp_ready) begin
                        resp_valid_q <= 1'b0;
                        rr_ptr_q     <= (owner_q == ID_W'(NUM_REQ - 1)) ? '0
                                        : ID_W'(owner_q + 1'b1);
                        busy_q       <= 1'b0;
                        state_q      <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready  = req_ready_q;
    assign mac_clr    = mac_clr_q;
    assign mac_start  = mac_start_q;
    assign mac_a      = mac_a_q;
    assign mac_b      = mac_b_q;
    assign resp_valid = resp_valid_q;
    assign resp_id    = resp_id_q;
    assign resp_sum   = resp_sum_q;
    assign resp_trunc = resp_trunc_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_tau_mac_sched.sv
// Testbench for tau_mac_sched: a behavioural MAC with fixed latency, simple
// per-requester producers, a table of single-job vectors and hand-written
// sequences for arbitration, back-pressure, reset mid-job and the watchdog.
module tb_tau_mac_sched;

    localparam int NR      = 2;
    localparam int BW      = 8;
    localparam int OW      = 16;
    localparam int ML      = 5;
    localparam int TO      = 8;
    localparam int MAC_LAT = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid;
    logic [NR-1:0]   req_ready;
    logic [NR*BW-1:0] req_a;
    logic [NR*BW-1:0] req_b;
    logic [NR-1:0]   req_last;
    logic            mac_clr;
    logic            mac_start;
    logic [BW-1:0]   mac_a;
    logic [BW-1:0]   mac_b;
    logic            mac_valid;
    logic [OW-1:0]   mac_sum;
    logic            resp_valid;
    logic            resp_ready;
    logic [0:0]      resp_id;
    logic [OW-1:0]   resp_sum;
    logic            resp_trunc;
    logic            resp_err;
    logic            busy;

    always #5 clk = ~clk;

    tau_mac_sched #(
        .NUM_REQ(NR), .BITWIDTH(BW), .OUT_WIDTH(OW), .MAX_LEN(ML),
        .ID_W(1), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_last(req_last),
        .mac_clr(mac_clr), .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
        .mac_valid(mac_valid), .mac_sum(mac_sum),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_trunc(resp_trunc), .resp_err(resp_err),
        .busy(busy)
    );

    // Behavioural MAC: result MAC_LAT edges after the start; stall drops the op.
    logic [OW-1:0] acc_m;
    logic [OW-1:0] sum_m;
    logic          valid_m;
    logic [BW-1:0] ma_m, mb_m;
    int unsigned   lat_m;
    logic          mac_stall;
    logic          mv_inj;

    always @(posedge clk) begin
        valid_m <= 1'b0;
        if (mac_clr) acc_m <= '0;
        if (mac_start) begin
            lat_m <= MAC_LAT;
            ma_m  <= mac_a;
            mb_m  <= mac_b;
        end else if (mac_stall) begin
            lat_m <= 0;
        end else if (lat_m == 1) begin
            lat_m   <= 0;
            valid_m <= 1'b1;
            sum_m   <= acc_m + 16'(ma_m) * 16'(mb_m);
            acc_m   <= acc_m + 16'(ma_m) * 16'(mb_m);
        end else if (lat_m != 0) begin
            lat_m <= lat_m - 1;
        end
    end

    // Stray-valid injection carries a bogus sum that must never be latched.
    assign mac_valid = valid_m | mv_inj;
    assign mac_sum   = mv_inj ? 16'hBEEF : sum_m;

    // Producers
    int unsigned rem [NR];
    logic [BW-1:0] pa [NR];
    logic [BW-1:0] pb [NR];
    bit          lst [NR];
    logic [NR-1:0] fire;
    int unsigned n_start, n_clr, n_acc;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_valid[i]       = (rem[i] != 0);
            req_a[i*BW +: BW]  = pa[i];
            req_b[i*BW +: BW]  = pb[i];
            req_last[i]        = lst[i] && (rem[i] == 1);
        end
    endtask

    task automatic load(input int id, input logic [BW-1:0] a, input logic [BW-1:0] b,
                        input int unsigned n, input bit l);
        pa[id] = a; pb[id] = b; rem[id] = n; lst[id] = l;
        drive();
    endtask

    // Advance one cycle; returns at the negedge with fresh samples.
    task automatic tick();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++)
            if (fire[i] && rem[i] != 0) rem[i]--;
        drive();
        @(negedge clk);
        fire  = req_valid & req_ready;
        n_acc += $countones(fire);
        if (mac_start === 1'b1) n_start++;
        if (mac_clr === 1'b1) n_clr++;
    endtask

    task automatic wait_resp(input int unsigned max);
        int unsigned c;
        c = 0;
        while (resp_valid !== 1'b1 && c < max) begin
            tick();
            c++;
        end
        chk("resp_seen", {63'b0, resp_valid}, 64'd1);
    endtask

    task automatic clr_counts();
        n_start = 0; n_clr = 0; n_acc = 0;
    endtask

    typedef struct {
        int unsigned id;
        logic [BW-1:0] a;
        logic [BW-1:0] b;
        int unsigned n;
        bit lst;
        logic [OW-1:0] sum;
        bit trunc;
        int unsigned acc;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int unsigned c, hold_err, clr0;
        vecs[0] = '{id: 0, a: 8'd1,   b: 8'd2,   n: 5, lst: 1'b1, sum: 16'd10,    trunc: 1'b0, acc: 5};
        vecs[1] = '{id: 1, a: 8'd2,   b: 8'd2,   n: 8, lst: 1'b0, sum: 16'd20,    trunc: 1'b1, acc: 5};
        vecs[2] = '{id: 1, a: 8'd255, b: 8'd255, n: 1, lst: 1'b1, sum: 16'd65025, trunc: 1'b0, acc: 1};
        vecs[3] = '{id: 0, a: 8'd255, b: 8'd255, n: 2, lst: 1'b1, sum: 16'd64514, trunc: 1'b0, acc: 2};
        vecs[4] = '{id: 0, a: 8'd7,   b: 8'd3,   n: 1, lst: 1'b1, sum: 16'd21,    trunc: 1'b0, acc: 1};

        for (int i = 0; i < NR; i++) begin
            rem[i] = 0; pa[i] = '0; pb[i] = '0; lst[i] = 1'b0;
        end
        fire = '0; mac_stall = 1'b0; mv_inj = 1'b0; resp_ready = 1'b1;
        reset = 1'b1;
        clr_counts();
        drive();
        @(negedge clk);
        tick();
        tick();
        chk("rst_outputs", {23'b0, req_ready, mac_clr, mac_start, mac_a, mac_b, resp_valid,
                            resp_id, resp_sum, resp_trunc, resp_err}, 64'd0);
        chk("rst_busy", {63'b0, busy}, 64'd0);
        reset = 1'b0;
        tick();

        // Table of single jobs.
        for (int v = 0; v < 5; v++) begin
            clr_counts();
            load(int'(vecs[v].id), vecs[v].a, vecs[v].b, vecs[v].n, vecs[v].lst);
            wait_resp(200);
            for (int i = 0; i < NR; i++) rem[i] = 0;
            drive();
            chk($sformatf("v%0d_id", v), 64'(resp_id), 64'(vecs[v].id));
            chk($sformatf("v%0d_sum", v), 64'(resp_sum), 64'(vecs[v].sum));
            chk($sformatf("v%0d_trunc", v), 64'(resp_trunc), 64'(vecs[v].trunc));
            chk($sformatf("v%0d_err", v), 64'(resp_err), 64'd0);
            chk($sformatf("v%0d_starts", v), 64'(n_start), 64'(vecs[v].acc));
            chk($sformatf("v%0d_accepted", v), 64'(n_acc), 64'(vecs[v].acc));
            chk($sformatf("v%0d_clears", v), 64'(n_clr), 64'd1);
            tick();
            tick();
        end

        // Both requesters valid from reset: req0 first, req1 gets a fresh clear.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clr_counts();
        load(0, 8'd3, 8'd1, 5, 1'b1);
        load(1, 8'd3, 8'd2, 1, 1'b1);
        wait_resp(200);
        chk("rr_first_id", 64'(resp_id), 64'd0);
        chk("rr_first_sum", 64'(resp_sum), 64'd15);
        tick();
        wait_resp(200);
        chk("rr_second_id", 64'(resp_id), 64'd1);
        chk("rr_second_sum", 64'(resp_sum), 64'd6);
        chk("rr_clears", 64'(n_clr), 64'd2);
        tick();
        tick();

        // Back-pressure: result held, no ready, no grant, stray mac_valid ignored.
        clr_counts();
        resp_ready = 1'b0;
        load(0, 8'd1, 8'd1, 1, 1'b1);
        load(1, 8'd2, 8'd3, 1, 1'b1);
        wait_resp(200);
        chk("bp_id", 64'(resp_id), 64'd0);
        chk("bp_sum", 64'(resp_sum), 64'd1);
        clr0 = n_clr;
        hold_err = 0;
        for (int k = 0; k < 10; k++) begin
            if (k == 3) mv_inj = 1'b1;
            tick();
            mv_inj = 1'b0;
            if (resp_valid !== 1'b1 || resp_sum !== 16'd1 || resp_id !== 1'b0 ||
                resp_trunc !== 1'b0 || req_ready !== '0 || busy !== 1'b1)
                hold_err++;
        end
        chk("bp_hold_stable", 64'(hold_err), 64'd0);
        chk("bp_no_clear", 64'(n_clr - clr0), 64'd0);
        resp_ready = 1'b1;
        tick();
        chk("bp_drop_valid", {62'b0, resp_valid, busy}, 64'd0);
        chk("bp_gap_no_clr", {63'b0, mac_clr}, 64'd0);
        tick();
        chk("bp_next_grant", {62'b0, mac_clr, busy}, 64'd3);
        wait_resp(200);
        chk("bp_next_id", 64'(resp_id), 64'd1);
        chk("bp_next_sum", 64'(resp_sum), 64'd6);
        tick();
        tick();

        // Reset while waiting on the MAC in a 3-pair job.
        clr_counts();
        mac_stall = 1'b1;
        load(0, 8'd1, 8'd1, 3, 1'b1);
        c = 0;
        while (n_start == 0 && c < 50) begin tick(); c++; end
        chk("rw_started", 64'(n_start), 64'd1);
        tick();
        tick();
        chk("rw_in_wait", {62'b0, busy, (mac_a == 8'd1)}, 64'd3);
        rem[0] = 0;
        drive();
        reset = 1'b1;
        tick();
        chk("rw_rst_outputs", {22'b0, busy, req_ready, mac_clr, mac_start, mac_a, mac_b,
                               resp_valid, resp_id, resp_sum, resp_trunc, resp_err}, 64'd0);
        reset = 1'b0;
        mac_stall = 1'b0;
        tick();
        chk("rw_idle", {63'b0, busy}, 64'd0);
        clr_counts();
        load(0, 8'd1, 8'd1, 2, 1'b1);
        wait_resp(200);
        chk("rw_next_sum", 64'(resp_sum), 64'd2);
        chk("rw_next_clears", 64'(n_clr), 64'd1);
        tick();
        tick();

`ifdef TAU_MAC_SCHED_TIMEOUT_EN
        // Watchdog: MAC never answers, response after TO cycles in WAIT.
        clr_counts();
        mac_stall = 1'b1;
        load(1, 8'd5, 8'd5, 2, 1'b1);
        c = 0;
        while (n_start == 0 && c < 50) begin tick(); c++; end
        c = 0;
        while (resp_valid !== 1'b1 && c < 100) begin tick(); c++; end
        chk("to_latency", 64'(c), 64'(TO + 1));
        chk("to_id", 64'(resp_id), 64'd1);
        chk("to_err", 64'(resp_err), 64'd1);
        chk("to_sum", 64'(resp_sum), 64'd0);
        chk("to_trunc", 64'(resp_trunc), 64'd0);
        rem[1] = 0;
        drive();
        mac_stall = 1'b0;
        tick();
        tick();
        load(1, 8'd2, 8'd5, 1, 1'b1);
        wait_resp(200);
        chk("to_next_sum", 64'(resp_sum), 64'd10);
        chk("to_next_err", 64'(resp_err), 64'd0);
        tick();
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
